// File: rtl/coproc_issuer.sv
// coproc_issuer: host-side instruction issuer for the matrix coprocessor.
//   Buffers host instruction words in a first-word-fall-through FIFO, issues them one
//   at a time over the instruction/activate_instruction/wait_signal handshake, and
//   returns READ results through a one-entry valid/ready response register.
// Ports:
//   clk, reset_n (async, active-low)
//   cmd_data/cmd_valid/cmd_ready        host command push
//   rsp_data/rsp_valid/rsp_ready        READ result to host
//   instruction, activate_instruction   word and issue strobe to the coprocessor
//   wait_signal, data_read              coprocessor busy flag and read data
//   busy                                FSM active or commands queued
//   err_timeout                         sticky watchdog flag
// Optional watchdog: define COPROC_ISSUER_TIMEOUT_EN to enable the TIMEOUT counter;
// otherwise err_timeout is 0 and the issuer waits indefinitely.
module coproc_issuer #(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] instruction,
    output logic        activate_instruction,
    input  logic        wait_signal,
    input  logic [15:0] data_read,
    output logic        busy,
    output logic        err_timeout
);
    localparam int         AW      = $clog2(CMD_DEPTH);
    localparam logic [3:0] OP_READ = 4'b0001;

    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
        $error("coproc_issuer: CMD_DEPTH must be a power of 2 >= 2 and TIMEOUT in 1..65535");
    end

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CAPTURE} state_t;
    state_t state, state_nxt;

    logic [31:0]   mem [CMD_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, load_rsp, timeout;

    assign cmd_ready            = count != (AW+1)'(CMD_DEPTH);
    assign push                 = cmd_valid && cmd_ready;
    // Never pop while the coprocessor still reports busy from a previous instruction.
    assign pop                  = state == IDLE && count != '0 && !wait_signal;
    assign busy                 = state != IDLE || count != '0;
    assign activate_instruction = state == ISSUE;

    always_comb begin
        state_nxt = state;
        load_rsp  = 1'b0;
        case (state)
            IDLE:      if (pop) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (wait_signal) state_nxt = WAIT_DONE;
            WAIT_DONE: if (!wait_signal) state_nxt = instruction[3:0] == OP_READ ? CAPTURE : IDLE;
            // Holding here while the previous result is unconsumed keeps responses in order.
            CAPTURE:   if (!rsp_valid || rsp_ready) begin
                           load_rsp  = 1'b1;
                           state_nxt = IDLE;
                       end
            default:   state_nxt = IDLE;
        endcase
        if (timeout) state_nxt = IDLE;
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= cmd_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            instruction <= '0;
            rsp_data    <= '0;
            rsp_valid   <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                instruction <= mem[rd_ptr];
            end
            if (load_rsp) rsp_data <= data_read;
            // A capture in the same cycle as a consume wins and keeps rsp_valid high.
            rsp_valid <= load_rsp || (rsp_valid && !rsp_ready);
        end
    end

`ifdef COPROC_ISSUER_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        waiting;

    assign waiting = state == WAIT_BUSY || state == WAIT_DONE;
    // Fires in the TIMEOUT-th waiting cycle, i.e. as the counter reaches TIMEOUT.
    assign timeout = waiting && wd_cnt == 16'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            wd_cnt <= state == ISSUE ? '0 : waiting ? wd_cnt + 16'd1 : wd_cnt;
            if (timeout) err_timeout <= 1'b1;
        end
    end
`else
    assign timeout     = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_coproc_issuer.sv
// tb_coproc_issuer: self-checking bench for coproc_issuer with a behavioural coprocessor model.
module tb_coproc_issuer;
    localparam int         DEPTH   = 4;
    localparam int         TMO     = 16;
    localparam logic [3:0] OP_READ = 4'h1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cmd_data = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] instruction;
    logic        activate_instruction;
    logic        wait_signal = 1'b0;
    logic [15:0] data_read = '0;
    logic        busy;
    logic        err_timeout;

    coproc_issuer #(.CMD_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .instruction(instruction), .activate_instruction(activate_instruction),
        .wait_signal(wait_signal), .data_read(data_read),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Coprocessor model: on a strobe it records the word, goes busy for busy_len cycles
    // (or a random length), and serves READ data from rd_q or a random value.
    int          busy_len = 3;
    bit          rand_len = 0;
    bit          hold_busy = 0;
    int          cnt = 0;
    int          viol = 0;
    time         fall_t = 0;
    time         t_push = 0;
    logic [31:0] issued[$];
    time         act_t[$];
    logic [15:0] rd_q[$];
    logic [15:0] exp_rsp[$];
    logic [15:0] got[$];

    always @(posedge clk) begin : model
        logic [15:0] v;
        if (!reset_n) begin
            cnt = 0;
            wait_signal <= 1'b0;
        end else if (activate_instruction) begin
            if (cnt > 0) viol++;
            issued.push_back(instruction);
            act_t.push_back($time);
            if (instruction[3:0] == OP_READ) begin
                if (rd_q.size() > 0) v = rd_q.pop_front();
                else v = 16'($urandom);
                data_read <= v;
                exp_rsp.push_back(v);
            end
            cnt = rand_len ? int'($urandom_range(1, 6)) : busy_len;
            wait_signal <= 1'b1;
        end else if (cnt > 0 && !hold_busy) begin
            cnt--;
            if (cnt == 0) begin
                wait_signal <= 1'b0;
                fall_t = $time;
            end
        end
    end

    always @(posedge clk)
        if (reset_n && rsp_valid && rsp_ready) got.push_back(rsp_data);

    task automatic clear_logs;
        issued.delete(); act_t.delete(); got.delete(); exp_rsp.delete(); rd_q.delete();
        viol = 0;
    endtask

    task automatic push(input logic [31:0] w, output bit rdy);
        @(negedge clk);
        cmd_data  = w;
        cmd_valid = 1'b1;
        rdy       = cmd_ready;
        @(posedge clk);
        t_push = $time;
    endtask

    task automatic stop_cmd;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_quiet(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy && !wait_signal && !rsp_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instruction: got %h want 0", instruction); end
        checks++; if ({activate_instruction, rsp_valid, busy, err_timeout} !== 4'b0000) begin errors++; $display("FAIL reset_flags: act/rv/busy/err got %b want 0000", {activate_instruction, rsp_valid, busy, err_timeout}); end
        checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read;
        bit  rdy;
        time trsp;
        clear_logs();
        busy_len  = 5;
        rsp_ready = 1'b0;
        rd_q.push_back(16'h1234);
        push(32'h0000_0A01, rdy);
        stop_cmd();
        for (int i = 0; i < 60 && !rsp_valid; i++) @(negedge clk);
        trsp = $time;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
        checks++; if (issued.size() != 1) begin errors++; $display("FAIL single_strobes: got %0d want 1", issued.size()); end
        checks++; if (act_t.size() < 1 || act_t[0] != t_push + 20) begin errors++; $display("FAIL single_issue_latency: strobe at %0t want %0t", act_t.size() ? act_t[0] : 0, t_push + 20); end
        checks++; if (trsp != fall_t + 25) begin errors++; $display("FAIL single_read_latency: rsp_valid seen at %0t want %0t", trsp, fall_t + 25); end
        checks++; if (rsp_data !== 16'h1234) begin errors++; $display("FAIL single_rsp_data: got %h want 1234", rsp_data); end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || got.size() != 1) begin errors++; $display("FAIL single_consume: rsp_valid %b responses %0d want 0 and 1", rsp_valid, got.size()); end
    endtask

    task automatic test_mixed_order;
        bit          rdy, ok;
        logic [31:0] w[3] = '{32'h0005_0002, 32'h0000_0003, 32'h0000_0501};
        int          bad = 0;
        clear_logs();
        busy_len  = 4;
        rsp_ready = 1'b1;
        rd_q.push_back(16'h0BAD);
        foreach (w[i]) push(w[i], rdy);
        stop_cmd();
        wait_quiet(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mixed_drain: busy %b still set after 200 cycles, want 0", busy); end
        if (issued.size() != 3) bad = 1;
        else foreach (w[i]) if (issued[i] !== w[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL mixed_order: %0d strobes, %0d wrong, want 3 in order", issued.size(), bad); end
        checks++; if (viol != 0) begin errors++; $display("FAIL mixed_overlap: %0d strobes while busy, want 0", viol); end
        checks++; if (act_t.size() < 3 || act_t[1] - act_t[0] != 70 || act_t[2] - act_t[1] != 70) begin errors++; $display("FAIL mixed_back_to_back: strobe gaps not %0d cycles", 7); end
        checks++; if (got.size() != 1 || got[0] !== 16'h0BAD) begin errors++; $display("FAIL mixed_response: %0d responses first %h want 1 x 0bad", got.size(), got.size() ? got[0] : 16'h0); end
    endtask

    task automatic test_fifo_full;
        bit          rdy, ok, exp_rdy;
        int          occ = 0, bad = 0;
        logic [31:0] exp_q[$];
        clear_logs();
        busy_len  = 2;
        hold_busy = 1;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] wd;
            wd = 32'hA000_0004 | (i << 8);
            push(wd, rdy);
            exp_rdy = occ < DEPTH;
            if (exp_rdy) begin
                occ++;
                exp_q.push_back(wd);
            end
            // The first word leaves the FIFO in the same cycle the second one arrives.
            if (i == 1) occ--;
            checks++; if (rdy !== exp_rdy) begin errors++; $display("FAIL full_ready_%0d: got %b want %b", i, rdy, exp_rdy); end
        end
        stop_cmd();
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_hold: cmd_ready %b want 0", cmd_ready); end
        hold_busy = 0;
        wait_quiet(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_drain: busy %b still set, want 0", busy); end
        if (issued.size() != exp_q.size()) bad = 1;
        else foreach (exp_q[i]) if (issued[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL full_order: %0d issued, %0d wrong, want %0d in order", issued.size(), bad, exp_q.size()); end
    endtask

    task automatic test_backpressure;
        bit rdy, ok;
        clear_logs();
        busy_len  = 3;
        rsp_ready = 1'b0;
        rd_q.push_back(16'h0001);
        rd_q.push_back(16'h0002);
        push(32'h0000_0101, rdy);
        push(32'h0000_0201, rdy);
        push(32'h0000_0302, rdy);
        stop_cmd();
        repeat (60) @(negedge clk);
        checks++; if (issued.size() != 2) begin errors++; $display("FAIL bp_held_issue: %0d strobes want 2", issued.size()); end
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0001) begin errors++; $display("FAIL bp_first_rsp: valid %b data %h want 1 0001", rsp_valid, rsp_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b want 1", busy); end
        rsp_ready = 1'b1;
        wait_quiet(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_drain: busy %b still set, want 0", busy); end
        checks++; if (got.size() != 2 || got[0] !== 16'h0001 || got[1] !== 16'h0002) begin errors++; $display("FAIL bp_order: %0d responses, want 0001 then 0002", got.size()); end
        checks++; if (issued.size() != 3 || issued[2] !== 32'h0000_0302) begin errors++; $display("FAIL bp_third: %0d strobes, want third 00000302", issued.size()); end
    endtask

    task automatic test_reset_mid;
        bit rdy, ok;
        int n0;
        clear_logs();
        busy_len  = 8;
        rsp_ready = 1'b0;
        rd_q.push_back(16'hBEEF);
        push(32'h0000_0701, rdy);
        stop_cmd();
        for (int i = 0; i < 60 && !rsp_valid; i++) @(negedge clk);
        push(32'h0000_0802, rdy);
        push(32'h0000_0902, rdy);
        push(32'h0000_0A02, rdy);
        stop_cmd();
        for (int i = 0; i < 20 && !wait_signal; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (instruction !== 32'h0 || activate_instruction !== 1'b0) begin errors++; $display("FAIL rstmid_instr: %h/%b want 0/0", instruction, activate_instruction); end
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0) begin errors++; $display("FAIL rstmid_rsp: %b/%h want 0/0000", rsp_valid, rsp_data); end
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_fifo: ready %b busy %b want 1 0", cmd_ready, busy); end
        n0 = issued.size();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (issued.size() != n0) begin errors++; $display("FAIL rstmid_no_strobe: %0d strobes want %0d", issued.size(), n0); end
        rsp_ready = 1'b1;
        push(32'h0000_0B02, rdy);
        stop_cmd();
        wait_quiet(100, ok);
        checks++; if (!ok || issued.size() != n0 + 1 || issued[issued.size()-1] !== 32'h0000_0B02) begin errors++; $display("FAIL rstmid_resume: %0d strobes want %0d ending 00000b02", issued.size(), n0 + 1); end
    endtask

    task automatic test_watchdog;
        bit  rdy, ok;
        time ta;
        clear_logs();
        busy_len  = 3;
        rsp_ready = 1'b1;
        hold_busy = 1;
`ifdef COPROC_ISSUER_TIMEOUT_EN
        push(32'h0000_0901, rdy);
        stop_cmd();
        for (int i = 0; i < 20 && act_t.size() == 0; i++) @(negedge clk);
        ta = act_t.size() ? act_t[0] : $time;
        while ($time < ta + 155) @(negedge clk);
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL wd_early: err_timeout %b want 0", err_timeout); end
        @(negedge clk);
        checks++; if (err_timeout !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wd_fire: err %b busy %b want 1 0", err_timeout, busy); end
        checks++; if (instruction !== 32'h0000_0901) begin errors++; $display("FAIL wd_instr: got %h want 00000901", instruction); end
        hold_busy = 0;
        wait_quiet(50, ok);
        checks++; if (!ok || got.size() != 0 || err_timeout !== 1'b1) begin errors++; $display("FAIL wd_no_rsp: responses %0d err %b want 0 and 1", got.size(), err_timeout); end
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL wd_clear: err_timeout %b want 0", err_timeout); end
`else
        ta = $time;
        push(32'h0000_0902, rdy);
        stop_cmd();
        repeat (40) @(negedge clk);
        checks++; if (err_timeout !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wd_off_wait: err %b busy %b want 0 1 (started %0t)", err_timeout, busy, ta); end
        hold_busy = 0;
        wait_quiet(50, ok);
        checks++; if (!ok || issued.size() != 1) begin errors++; $display("FAIL wd_off_finish: %0d strobes want 1", issued.size()); end
`endif
        hold_busy = 0;
    endtask

    task automatic test_random;
        localparam int N = 24;
        logic [31:0] exp_q[$];
        logic [3:0]  op;
        bit          rdy_prev = 0, ok;
        int          sent = 0, guard = 0, bad = 0;
        clear_logs();
        rand_len = 1;
        while ((sent < N || cmd_valid || busy || rsp_valid) && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (cmd_valid && rdy_prev) begin
                exp_q.push_back(cmd_data);
                sent++;
                cmd_valid = 1'b0;
            end
            if (!cmd_valid && sent < N && $urandom_range(0, 2) != 0) begin
                op        = $urandom_range(0, 3) == 0 ? OP_READ : 4'($urandom_range(2, 15));
                cmd_data  = {28'($urandom), op};
                cmd_valid = 1'b1;
            end
            rdy_prev  = cmd_ready;
            rsp_ready = 1'($urandom_range(0, 1));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_quiet(50, ok);
        rand_len = 0;
        checks++; if (guard >= 4000 || !ok) begin errors++; $display("FAIL rand_drain: did not finish in %0d cycles", guard); end
        if (issued.size() != exp_q.size()) bad = 1;
        else foreach (exp_q[i]) if (issued[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_issue_order: %0d issued, %0d wrong, want %0d", issued.size(), bad, exp_q.size()); end
        bad = 0;
        if (got.size() != exp_rsp.size()) bad = 1;
        else foreach (exp_rsp[i]) if (got[i] !== exp_rsp[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_responses: %0d got, %0d wrong, want %0d", got.size(), bad, exp_rsp.size()); end
        checks++; if (viol != 0) begin errors++; $display("FAIL rand_overlap: %0d strobes while busy want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_mixed_order();
        test_fifo_full();
        test_backpressure();
        test_reset_mid();
        test_watchdog();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
